er_key_reader: RTL
==================

# er_key_reader

Reads a frame's reconciled key out of the reconciled-key BRAM once error reconciliation finishes, and streams it as 32-bit words into a downstream write-side FIFO. It is the read-side counterpart of the ER reconciled-key writer: the single-frame ER core fills one 16384-word half of the BRAM, and this block drains that half toward privacy amplification or the host link. One instance sits on each of the Alice and Bob sides.

## Interface

Parameters:
- RD_LATENCY, 2: BRAM read latency in cycles from enb/addrb to valid doutb. Legal values are 1 to 3.
- HALF_WORDS, 16384: number of 64-bit words in one BRAM half.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle pulse that begins a drain. Honoured only in IDLE.
- ev_fail  in  1  error-verification fail flag, sampled together with start.
- addr_index  in  1  selects the half: 0 = addr 0..16383, 1 = addr 16384..32767. Sampled on start.
- word_count  in  15  number of 64-bit words to read. Sampled on start; values above HALF_WORDS are clamped to HALF_WORDS.
- key_clkb  out  1  tied to clk.
- key_enb  out  1  BRAM enable.
- key_web  out  1  constant 0.
- key_addrb  out  15  BRAM address.
- key_doutb  in  64  BRAM read data.
- fifo_wr_clk  out  1  tied to clk.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_din  out  32  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_ack  in  1  FIFO write acknowledge, one cycle after an accepted write.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when the drain completes.
- aborted  out  1  one-cycle pulse when start is rejected because ev_fail was high.
- words_sent  out  16  count of fifo_wr_ack pulses since the last accepted start.

## Operation

- States are IDLE, RD, WAIT, HI, LO, DONE.
- IDLE transitions on start:
  - ev_fail = 1: set aborted for one cycle and stay in IDLE. words_sent is not cleared.
  - ev_fail = 0 and the clamped word_count = 0: go to DONE.
  - Otherwise: latch base = addr_index ? 16384 : 0, latch N = the clamped count, clear the word index i and words_sent, and go to RD.
- RD (1 cycle): key_enb = 1, key_addrb = base + i. Go to WAIT.
- WAIT (RD_LATENCY cycles): key_enb = 0. On the last WAIT cycle, capture key_doutb into a 64-bit register W. Go to HI.
- HI: fifo_wr_din = W[63:32] and fifo_wr_en = ~fifo_full, combinationally. Stay in HI while fifo_full = 1; go to LO on the first cycle with fifo_full = 0.
- LO: fifo_wr_din = W[31:0] and fifo_wr_en = ~fifo_full; same stall rule as HI. On a write: if i = N-1, go to DONE; otherwise increment i and go to RD.
- DONE (1 cycle): done = 1, then go to IDLE.
- Word order: for each 64-bit word, the upper half is written first, then the lower half. Words go out in ascending address order.
- words_sent increments on every fifo_wr_ack in any state, saturating at 0xFFFF. After a full drain it ends at 2N.
- The block never writes while fifo_full = 1, so every strobe is expected to be acknowledged.
- Address arithmetic is 15-bit. base + i never exceeds 32767 because N is at most 16384.

## Timing

- Reset values: key_enb = 0, key_addrb = 0, key_web = 0, fifo_wr_en = 0, fifo_wr_din = 0, busy = 0, done = 0, aborted = 0, words_sent = 0, W = 0, state = IDLE.
- Assertion of rst_n = 0 in any state returns the block to IDLE with reset values on the next clk edge. A partially written word is not completed.
- start is ignored while busy = 1.
- Timing with no backpressure, counting the start cycle as cycle 0:
  - RD at cycle 1.
  - W is captured at cycle 1 + RD_LATENCY.
  - HI write at cycle 2 + RD_LATENCY.
  - LO write at cycle 3 + RD_LATENCY.
  - Steady state is 3 + RD_LATENCY cycles per 64-bit word.
  - done fires 1 cycle after the last LO write.
- word_count = 0 gives done at cycle 1 with no BRAM access and no FIFO write.
- Each cycle with fifo_full = 1 in HI or LO adds exactly one cycle. W holds its value while stalled.
- fifo_wr_en is never high outside HI and LO.
- done and aborted are never high in the same cycle.

## Test plan

- Single word: BRAM[0] = 0x0123456789ABCDEF, addr_index = 0, word_count = 1, RD_LATENCY = 2, fifo_full = 0. Expect FIFO writes 0x01234567 at cycle 4 and 0x89ABCDEF at cycle 5, done at cycle 6, and words_sent = 2.
- Upper half, 3 words: addr_index = 1, word_count = 3, BRAM[16384 + k] = k. Expect key_addrb sequence 16384, 16385, 16386 and FIFO stream 0,0,0,1,0,2. words_sent = 6, with 5 cycles per word.
- Backpressure: word_count = 2, fifo_full held high for 4 cycles while in LO of word 0. Expect no wr_en during the stall, lower half written on the first low cycle, no data lost or duplicated, and done 4 cycles later than the unstalled case.
- Abort and empty: start with ev_fail = 1 gives aborted pulse, key_enb never asserted, busy stays 0. Start with word_count = 0 gives done at cycle 1 and no writes. Start with word_count = 20000 on index 0 gives exactly 16384 reads, the last at addr 16383.
- Reset mid-drain: rst_n low for 1 cycle during WAIT of word 5. Expect all outputs at reset values the next cycle and words_sent = 0; a new start restarts from addr base + 0.
- Start while busy: a second start pulse during HI is ignored. Latched count and base are unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/er_key_reader_if.sv
// BRAM read port and FIFO write port seen by the reconciled-key reader.
// The master side belongs to the reader; the slave side belongs to the memory and FIFO.
interface er_key_reader_if;
    logic        key_clkb;
    logic        key_enb;
    logic        key_web;
    logic [14:0] key_addrb;
    logic [63:0] key_doutb;
    logic        fifo_wr_clk;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_din;
    logic        fifo_full;
    logic        fifo_wr_ack;

    modport master (
        output key_clkb, key_enb, key_web, key_addrb,
        output fifo_wr_clk, fifo_wr_en, fifo_wr_din,
        input  key_doutb, fifo_full, fifo_wr_ack
    );

    modport slave (
        input  key_clkb, key_enb, key_web, key_addrb,
        input  fifo_wr_clk, fifo_wr_en, fifo_wr_din,
        output key_doutb, fifo_full, fifo_wr_ack
    );
endinterface

// File: rtl/er_key_reader.sv
// Drains one half of the reconciled-key BRAM into a 32-bit FIFO.
// Each 64-bit word is sent upper half first, in ascending address order.
module er_key_reader #(
    parameter int RD_LATENCY = 2,
    parameter int HALF_WORDS = 16384
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 ev_fail,
    input  logic                 addr_index,
    input  logic [14:0]          word_count,
    er_key_reader_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [15:0]          words_sent
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, HI, LO, DONE} state_t;

    localparam logic [15:0] HALF = 16'(HALF_WORDS);
    localparam logic [1:0]  LAST = 2'(RD_LATENCY - 1);

    state_t      state_q;
    logic [14:0] base_q, n_q, idx_q, addr_q;
    logic [63:0] w_q;
    logic [1:0]  wcnt_q;
    logic [15:0] sent_q;
    logic        enb_q, aborted_q;

    logic [14:0] n_clamp;
    logic [14:0] base_sel;

    assign n_clamp  = ({1'b0, word_count} > HALF) ? HALF[14:0] : word_count;
    assign base_sel = addr_index ? HALF[14:0] : 15'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            w_q       <= '0;
            wcnt_q    <= '0;
            sent_q    <= '0;
            enb_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            enb_q     <= 1'b0;
            aborted_q <= 1'b0;
            if (bus.fifo_wr_ack && sent_q != 16'hFFFF)
                sent_q <= sent_q + 16'd1;
            case (state_q)
                IDLE: if (start) begin
                    if (ev_fail) begin
                        aborted_q <= 1'b1;
                    end else if (n_clamp == 15'd0) begin
                        state_q <= DONE;
                    end else begin
                        // The clear overrides any ack landing in the start cycle.
                        base_q  <= base_sel;
                        n_q     <= n_clamp;
                        idx_q   <= '0;
                        sent_q  <= '0;
                        addr_q  <= base_sel;
                        enb_q   <= 1'b1;
                        state_q <= RD;
                    end
                end
                RD: begin
                    wcnt_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (wcnt_q == LAST) begin
                        w_q     <= bus.key_doutb;
                        state_q <= HI;
                    end else begin
                        wcnt_q <= wcnt_q + 2'd1;
                    end
                end
                HI: if (!bus.fifo_full) state_q <= LO;
                LO: if (!bus.fifo_full) begin
                    if (idx_q == n_q - 15'd1) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 15'd1;
                        addr_q  <= base_q + idx_q + 15'd1;
                        enb_q   <= 1'b1;
                        state_q <= RD;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write strobe follows fifo_full in the same cycle so a stall never drops a half.
    always_comb begin
        bus.fifo_wr_din = '0;
        bus.fifo_wr_en  = 1'b0;
        if (state_q == HI) begin
            bus.fifo_wr_din = w_q[63:32];
            bus.fifo_wr_en  = ~bus.fifo_full;
        end else if (state_q == LO) begin
            bus.fifo_wr_din = w_q[31:0];
            bus.fifo_wr_en  = ~bus.fifo_full;
        end
    end

    assign bus.key_clkb    = clk;
    assign bus.fifo_wr_clk = clk;
    assign bus.key_web     = 1'b0;
    assign bus.key_enb     = enb_q;
    assign bus.key_addrb   = addr_q;

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign words_sent = sent_q;
endmodule
